mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 14 +
 rtl/mult_div_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared CPU encodings for the multiply/divide unit: op codes and FSM states.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (radix-2 Booth) and signed divide (restoring, on
// magnitudes), one step per cycle; results land in hi/lo on completion.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic signed [WIDTH:0]   acc;
  logic [WIDTH-1:0]        q;
  logic [WIDTH-1:0]        m;
  logic                    q_m1;
  logic                    a_neg;
  logic                    b_neg;
  logic                    dz;

  logic signed [WIDTH:0]   m_ext;
  logic signed [WIDTH:0]   booth_sum;
  logic signed [WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0]        q_nxt;
  logic                    qm1_nxt;
  logic [WIDTH:0]          rem_sh;
  logic [WIDTH:0]          rem_diff;
  logic [WIDTH-1:0]        hi_fin;
  logic [WIDTH-1:0]        lo_fin;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic n);
    return n ? (~x + 1'b1) : x;
  endfunction

  always_comb begin
    m_ext     = $signed({m[WIDTH-1], m});
    booth_sum = acc;
    rem_sh    = {acc[WIDTH-1:0], q[WIDTH-1]};
    rem_diff  = rem_sh - {1'b0, m};
    acc_nxt   = acc;
    q_nxt     = q;
    qm1_nxt   = q_m1;
    if (state == MULT) begin
      case ({q[0], q_m1})
        2'b01:   booth_sum = acc + m_ext;
        2'b10:   booth_sum = acc - m_ext;
        default: booth_sum = acc;
      endcase
      // Accumulator carries one guard bit so a +/- 2^(WIDTH-1) multiplicand cannot overflow.
      acc_nxt = booth_sum >>> 1;
      q_nxt   = {booth_sum[0], q[WIDTH-1:1]};
      qm1_nxt = q[0];
    end else if (state == DIV) begin
      if (!rem_diff[WIDTH]) begin
        acc_nxt = $signed(rem_diff);
        q_nxt   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = $signed(rem_sh);
        q_nxt   = {q[WIDTH-2:0], 1'b0};
      end
    end
    // Remainder follows the dividend sign; quotient sign is the XOR of operand signs.
    if (state == DIV) begin
      hi_fin = neg_if(acc_nxt[WIDTH-1:0], a_neg);
      lo_fin = neg_if(q_nxt, a_neg ^ b_neg);
    end else begin
      hi_fin = acc_nxt[WIDTH-1:0];
      lo_fin = q_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      q        <= '0;
      m        <= '0;
      q_m1     <= 1'b0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      dz       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      // Status outputs are registered views of the state one cycle later.
      busy     <= (state == MULT) || (state == DIV);
      done     <= (state == DONE);
      div_zero <= (state == DONE) && dz;
      case (state)
        IDLE: begin
          if (start) begin
            a_neg <= a[WIDTH-1];
            b_neg <= b[WIDTH-1];
            cnt   <= '0;
            acc   <= '0;
            q_m1  <= 1'b0;
            dz    <= 1'b0;
            if (op == OP_MULT) begin
              m     <= a;
              q     <= b;
              state <= MULT;
            end else if (b == '0) begin
              dz    <= 1'b1;
              state <= DONE;
            end else begin
              m     <= magnitude(b);
              q     <= magnitude(a);
              state <= DIV;
            end
          end
        end
        MULT, DIV: begin
          acc  <= acc_nxt;
          q    <= q_nxt;
          q_m1 <= qm1_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            hi    <= hi_fin;
            lo    <= lo_fin;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
